// File: rtl/reg_wb_sched_if.sv
// Bundle of issue, writeback-request and register-file-write signals for reg_wb_sched.
interface reg_wb_sched_if;
   // Issue stage
   logic        iss_valid;
   logic        iss_ready;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic        iss_use1;
   logic        iss_use2;
   logic        iss_wr;
   logic [4:0]  iss_rd;
   // Writeback requesters
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   // Register file write port and status
   logic        rf_we;
   logic [4:0]  rf_wnum;
   logic [31:0] rf_wdata;
   logic [5:0]  pend_cnt;
   logic        wb_err;

   // Environment side: issue stage, execution units, register file
   modport master (
      output iss_valid, iss_rs1, iss_rs2, iss_use1, iss_use2, iss_wr, iss_rd,
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  iss_ready, alu_ready, lsu_ready,
      input  rf_we, rf_wnum, rf_wdata, pend_cnt, wb_err
   );

   // Scheduler side
   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, iss_use1, iss_use2, iss_wr, iss_rd,
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output iss_ready, alu_ready, lsu_ready,
      output rf_we, rf_wnum, rf_wdata, pend_cnt, wb_err
   );
endinterface

// File: rtl/reg_wb_sched.sv
// Register-file writeback scheduler: round-robin arbitration of ALU/LSU onto the single
// write port, plus a busy-bit scoreboard that stalls issue on RAW/WAW hazards.
module reg_wb_sched (
   input  logic               clk,
   input  logic               rst,
   reg_wb_sched_if.slave      bus
);

   logic [31:0] busy_q, busy_d;
   logic        rr_ptr_q, rr_ptr_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_wnum_q, rf_wnum_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;
   logic [5:0]  pend_q, pend_d;
   logic        wb_err_q, wb_err_d;

   logic        hazard;
   logic        alu_gnt, lsu_gnt, wb_any;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_nz;
   logic        set_any, clr_any;

   // Hazard detection, arbitration and next-state computation
   always_comb begin
      hazard  = (bus.iss_use1 && (bus.iss_rs1 != 5'd0) && busy_q[bus.iss_rs1]) ||
                (bus.iss_use2 && (bus.iss_rs2 != 5'd0) && busy_q[bus.iss_rs2]) ||
                (bus.iss_wr   && (bus.iss_rd  != 5'd0) && busy_q[bus.iss_rd]);

      // rr_ptr only matters when both units request
      alu_gnt = bus.alu_valid && (!bus.lsu_valid || !rr_ptr_q);
      lsu_gnt = bus.lsu_valid && (!bus.alu_valid ||  rr_ptr_q);
      wb_any  = alu_gnt || lsu_gnt;
      wb_rd   = alu_gnt ? bus.alu_rd   : bus.lsu_rd;
      wb_data = alu_gnt ? bus.alu_data : bus.lsu_data;
      wb_nz   = wb_any && (wb_rd != 5'd0);

      set_any = bus.iss_valid && !hazard && bus.iss_wr && (bus.iss_rd != 5'd0);
      // Only a genuinely busy register lowers the count; a stray writeback flags an error
      clr_any = wb_nz && busy_q[wb_rd];

      busy_d = busy_q;
      if (clr_any) busy_d[wb_rd] = 1'b0;
      if (set_any) busy_d[bus.iss_rd] = 1'b1;
      busy_d[0] = 1'b0;

      pend_d = pend_q + {5'd0, set_any} - {5'd0, clr_any};

      rr_ptr_d = rr_ptr_q;
      if (alu_gnt)      rr_ptr_d = 1'b1;
      else if (lsu_gnt) rr_ptr_d = 1'b0;

      rf_we_d    = wb_nz;
      rf_wnum_d  = wb_nz ? wb_rd   : 5'd0;
      rf_wdata_d = wb_nz ? wb_data : 32'd0;

      wb_err_d = wb_err_q || (wb_nz && !busy_q[wb_rd]);
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q     <= 32'd0;
         rr_ptr_q   <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_wnum_q  <= 5'd0;
         rf_wdata_q <= 32'd0;
         pend_q     <= 6'd0;
         wb_err_q   <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         rr_ptr_q   <= rr_ptr_d;
         rf_we_q    <= rf_we_d;
         rf_wnum_q  <= rf_wnum_d;
         rf_wdata_q <= rf_wdata_d;
         pend_q     <= pend_d;
         wb_err_q   <= wb_err_d;
      end
   end

   // Output drive
   always_comb begin
      bus.iss_ready = !hazard;
      bus.alu_ready = alu_gnt;
      bus.lsu_ready = lsu_gnt;
      bus.rf_we     = rf_we_q;
      bus.rf_wnum   = rf_wnum_q;
      bus.rf_wdata  = rf_wdata_q;
      bus.pend_cnt  = pend_q;
      bus.wb_err    = wb_err_q;
   end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed self-checking bench for reg_wb_sched.
module tb_reg_wb_sched;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   reg_wb_sched_if u_if ();

   reg_wb_sched u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_iss(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic wr,
                          input logic [4:0] rd);
      u_if.iss_valid = v;
      u_if.iss_rs1   = rs1;
      u_if.iss_use1  = u1;
      u_if.iss_rs2   = rs2;
      u_if.iss_use2  = u2;
      u_if.iss_wr    = wr;
      u_if.iss_rd    = rd;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      u_if.alu_valid = v;
      u_if.alu_rd    = rd;
      u_if.alu_data  = d;
   endtask

   task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      u_if.lsu_valid = v;
      u_if.lsu_rd    = rd;
      u_if.lsu_data  = d;
   endtask

   task automatic idle_all();
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle_all();
      rst = 1'b0;
      #12;
      // Reset state
      check_eq("rst_rf_we",    32'(u_if.rf_we),     32'd0);
      check_eq("rst_rf_wnum",  32'(u_if.rf_wnum),   32'd0);
      check_eq("rst_rf_wdata", u_if.rf_wdata,       32'd0);
      check_eq("rst_pend",     32'(u_if.pend_cnt),  32'd0);
      check_eq("rst_wb_err",   32'(u_if.wb_err),    32'd0);
      check_eq("rst_iss_rdy",  32'(u_if.iss_ready), 32'd1);
      check_eq("rst_alu_rdy",  32'(u_if.alu_ready), 32'd0);
      check_eq("rst_lsu_rdy",  32'(u_if.lsu_ready), 32'd0);
      rst = 1'b1;
      tick();

      // Issue rd=5
      set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
      #1 check_eq("iss5_rdy", 32'(u_if.iss_ready), 32'd1);
      tick();
      // RAW on x5 stalls; ALU writes back x5 this cycle
      set_iss(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
      set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      check_eq("raw5_rdy",  32'(u_if.iss_ready), 32'd0);
      check_eq("raw5_pend", 32'(u_if.pend_cnt),  32'd1);
      check_eq("alu5_rdy",  32'(u_if.alu_ready), 32'd1);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      #1;
      check_eq("wb5_we",    32'(u_if.rf_we),     32'd1);
      check_eq("wb5_wnum",  32'(u_if.rf_wnum),   32'd5);
      check_eq("wb5_wdata", u_if.rf_wdata,       32'hDEAD_BEEF);
      check_eq("wb5_rdy",   32'(u_if.iss_ready), 32'd1);
      check_eq("wb5_pend",  32'(u_if.pend_cnt),  32'd0);
      tick();

      // LSU writeback to x0 (harmless, hands priority back to ALU); issue rd=3
      set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
      set_lsu(1'b1, 5'd0, 32'h1234_5678);
      #1 check_eq("lsu0_rdy", 32'(u_if.lsu_ready), 32'd1);
      tick();
      set_lsu(1'b0, 5'd0, 32'd0);
      set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
      #1;
      check_eq("wb0_we",    32'(u_if.rf_we),   32'd0);
      check_eq("wb0_wnum",  32'(u_if.rf_wnum), 32'd0);
      check_eq("wb0_wdata", u_if.rf_wdata,     32'd0);
      check_eq("wb0_err",   32'(u_if.wb_err),  32'd0);
      tick();

      // Two round-robin rounds of simultaneous ALU(x3)/LSU(x4)
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
            tick();
            set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
            tick();
         end
         set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
         set_alu(1'b1, 5'd3, 32'h0000_0033);
         set_lsu(1'b1, 5'd4, 32'h0000_0044);
         #1;
         check_eq("rr_pend2",   32'(u_if.pend_cnt),  32'd2);
         check_eq("rr_alu_rdy", 32'(u_if.alu_ready), 32'd1);
         check_eq("rr_lsu_rdy", 32'(u_if.lsu_ready), 32'd0);
         tick();
         set_alu(1'b0, 5'd0, 32'd0);
         #1;
         check_eq("rr_wnum3",   32'(u_if.rf_wnum),   32'd3);
         check_eq("rr_wdata3",  u_if.rf_wdata,       32'h33);
         check_eq("rr_lsu_rdy2", 32'(u_if.lsu_ready), 32'd1);
         tick();
         set_lsu(1'b0, 5'd0, 32'd0);
         #1;
         check_eq("rr_we4",    32'(u_if.rf_we),    32'd1);
         check_eq("rr_wnum4",  32'(u_if.rf_wnum),  32'd4);
         check_eq("rr_pend0",  32'(u_if.pend_cnt), 32'd0);
         check_eq("rr_err",    32'(u_if.wb_err),   32'd0);
      end
      tick();

      // WAW on x7
      set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
      tick();
      #1 check_eq("waw7_rdy", 32'(u_if.iss_ready), 32'd0);
      // Writing x0 never hazards and does not count
      set_iss(1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b1, 5'd0);
      #1 check_eq("rd0_rdy", 32'(u_if.iss_ready), 32'd1);
      tick();
      set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
      set_alu(1'b1, 5'd7, 32'h0000_0777);
      #1;
      check_eq("rd0_pend",  32'(u_if.pend_cnt),  32'd1);
      check_eq("waw7_rdy2", 32'(u_if.iss_ready), 32'd0);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      #1;
      check_eq("waw7_wnum", 32'(u_if.rf_wnum),   32'd7);
      check_eq("waw7_rdy3", 32'(u_if.iss_ready), 32'd1);
      check_eq("waw7_pend", 32'(u_if.pend_cnt),  32'd0);
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      tick();

      // Writeback to non-busy x9 sets sticky error
      set_lsu(1'b1, 5'd9, 32'h0000_0999);
      tick();
      set_lsu(1'b0, 5'd0, 32'd0);
      #1;
      check_eq("err9_we",   32'(u_if.rf_we),    32'd1);
      check_eq("err9_wnum", 32'(u_if.rf_wnum),  32'd9);
      check_eq("err9_err",  32'(u_if.wb_err),   32'd1);
      check_eq("err9_pend", 32'(u_if.pend_cnt), 32'd0);
      tick();
      check_eq("err9_we_idle", 32'(u_if.rf_we),  32'd0);
      check_eq("err9_sticky",  32'(u_if.wb_err), 32'd1);

      // Fill x1..x31
      for (int i = 1; i < 32; i++) begin
         set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'(i));
         tick();
      end
      set_iss(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
      set_alu(1'b1, 5'd1, 32'hCAFE_0001);
      #1;
      check_eq("full_pend", 32'(u_if.pend_cnt),  32'd31);
      check_eq("full_rdy",  32'(u_if.iss_ready), 32'd0);
      // Asynchronous reset mid-cycle with a writeback pending
      #1 rst = 1'b0;
      #1;
      check_eq("arst_pend", 32'(u_if.pend_cnt), 32'd0);
      check_eq("arst_we",   32'(u_if.rf_we),    32'd0);
      check_eq("arst_err",  32'(u_if.wb_err),   32'd0);
      check_eq("arst_rdy",  32'(u_if.iss_ready), 32'd1);
      tick();
      idle_all();
      #1 rst = 1'b1;
      tick();
      check_eq("post_we",   32'(u_if.rf_we),    32'd0);
      check_eq("post_wnum", 32'(u_if.rf_wnum),  32'd0);
      check_eq("post_pend", 32'(u_if.pend_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
